load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ROM_LIMIT, default 32'h0002_0000; stores below this address fault.
REQ-002 SHALL have parameter ADDR_LIMIT, default 32'h0003_FFFB; accesses above this address fault.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  core request present.
REQ-006 req_ready  output  1  LSU accepts a request; high only in IDLE.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_signed  input  1  sign-extend byte/halfword loads.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 rsp_valid  output  1  response present; held until rsp_ready.
REQ-013 rsp_ready  input  1  core consumes response.
REQ-014 rsp_rdata  output  32  load result, zero- or sign-extended; 0 for stores and faults.
REQ-015 rsp_fault  output  1  access was rejected.
REQ-016 mem_addr  output  32  byte base address to memory.
REQ-017 mem_w_en  output  1  memory write strobe for a full 4-byte little-endian word at mem_addr.
REQ-018 mem_w_data  output  32  merged write word.
REQ-019 mem_r_data  input  32  combinational little-endian read of bytes mem_addr..mem_addr+3.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP.
REQ-021 IDLE: when req_valid && req_ready, SHALL capture write, size, signed, addr and wdata.
REQ-022 On capture, SHALL evaluate the fault condition: size==11; halfword with addr[0]!=0; word with addr[1:0]!=0; addr>ADDR_LIMIT; store with addr<ROM_LIMIT.
REQ-023 Faulting request SHALL go IDLE->RESP with rsp_fault=1 and rsp_rdata=0, and SHALL never assert mem_w_en.
REQ-024 Non-faulting request SHALL go IDLE->ACCESS, with mem_addr equal to the captured addr from ACCESS onward.
REQ-025 ACCESS, load: SHALL register the extracted value (byte = r_data[7:0], half = [15:0], word = [31:0], extended per signed), then go to RESP.
REQ-026 ACCESS, store: SHALL register the merge of wdata into r_data (byte replaces [7:0], half replaces [15:0], word replaces all), then go to WRITE.
REQ-027 WRITE: mem_w_en=1 for exactly one cycle with the merged data, then go to RESP.
REQ-028 Latency from the accept edge to rsp_valid SHALL be: load 2 cycles; store 3 cycles; fault 1 cycle.
REQ-029 RESP: rsp_valid=1 with stable outputs; on rsp_ready, SHALL go to IDLE. A new request is accepted no earlier than the following cycle (no bypass).
REQ-030 req_signed SHALL be ignored for word loads and for stores.
REQ-031 Outside WRITE, mem_w_en SHALL be 0.

Reset
REQ-032 When rst is high at posedge, the next state SHALL be IDLE regardless of the current state, including mid-ACCESS or mid-WRITE.
REQ-033 Reset values: req_ready=1, rsp_valid=0, rsp_fault=0, rsp_rdata=0, mem_w_en=0, mem_addr=0, mem_w_data=0, all captured registers 0.
REQ-034 A request pending during rst SHALL be dropped with no response; an already-completed write is not undone.

Structure
REQ-035 A shared header SHALL hold the size encodings, FSM state codes, ROM_LIMIT and ADDR_LIMIT.
REQ-036 Sub-module lsu_align SHALL be purely combinational: extract/extend for loads, merge for stores. The FSM and registers stay in load_store_unit.

Verification
REQ-037 Preload bytes 0xFA..0xFD = FF DC BA 98. Unsigned byte load at 0xFA -> rsp_rdata 0x000000FF, fault 0, 2-cycle latency.
REQ-038 Signed halfword load at 0xFA -> 0xFFFFDCFF. Signed byte load at 0xFD -> 0xFFFFFF98.
REQ-039 Byte store 0x55 at 0x0002_0010 (holding 0x11223344), then word load -> 0x11223355. mem_w_en high exactly one cycle; store latency 3.
REQ-040 Each of these -> rsp_fault=1 after 1 cycle, mem_w_en never asserted, memory unchanged:
- word load at 0x0002_0002;
- halfword store at 0x0002_0001;
- word store at 0x0000_0100 (ROM);
- size 11.
REQ-041 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; release -> IDLE next cycle.
REQ-042 Assert rst during ACCESS of a store -> no mem_w_en, no rsp_valid, req_ready=1 the next cycle, target word unchanged.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings, address limits and the access-fault rule for the load/store unit.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WRITE  = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  localparam logic [31:0] ROM_LIMIT_DEF  = 32'h0002_0000;
  localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0003_FFFB;

  // A request faults on an illegal size, misalignment, an address past the
  // top of memory, or a store into the read-only region.
  function automatic logic access_fault(
    input logic        write,
    input logic [1:0]  size,
    input logic [31:0] addr,
    input logic [31:0] rom_limit,
    input logic [31:0] addr_limit
  );
    logic f;
    f = 1'b0;
    case (size_e'(size))
      SZ_HALF: f = addr[0];
      SZ_WORD: f = |addr[1:0];
      SZ_ILL:  f = 1'b1;
      default: f = 1'b0;
    endcase
    if (addr > addr_limit) f = 1'b1;
    if (write && (addr < rom_limit)) f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: extract/extend a load value from a memory word,
// or merge right-justified store data into the low bytes of that word.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] r_data_i,
  input  logic [31:0] w_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  always_comb begin
    load_data_o  = '0;
    merge_data_o = r_data_i;
    case (size_e'(size_i))
      SZ_BYTE: begin
        load_data_o  = {{24{signed_i & r_data_i[7]}}, r_data_i[7:0]};
        merge_data_o = {r_data_i[31:8], w_data_i[7:0]};
      end
      SZ_HALF: begin
        load_data_o  = {{16{signed_i & r_data_i[15]}}, r_data_i[15:0]};
        merge_data_o = {r_data_i[31:16], w_data_i[15:0]};
      end
      SZ_WORD: begin
        // Full word: sign selection has no effect.
        load_data_o  = r_data_i;
        merge_data_o = w_data_i;
      end
      default: begin
        load_data_o  = '0;
        merge_data_o = r_data_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit; rsp_valid 1 (fault), 2 (load), 3 (store) edges after accept.
// Accepts only in IDLE; response is held stable until rsp_ready, with no same-cycle bypass.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] ROM_LIMIT  = ROM_LIMIT_DEF,
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_w_en,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wword_q, wword_d;

  logic [31:0] load_data;
  logic [31:0] merge_data;

  lsu_align u_align (
    .size_i       (size_q),
    .signed_i     (signed_q),
    .r_data_i     (mem_r_data),
    .w_data_i     (wdata_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
      wword_q  <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
      wword_q  <= wword_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    wword_d  = wword_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          fault_d  = access_fault(req_write, req_size, req_addr, ROM_LIMIT, ADDR_LIMIT);
          state_d  = fault_d ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Memory read data is valid here because mem_addr already holds the captured address.
        if (write_q) begin
          wword_d = merge_data;
          state_d = ST_WRITE;
        end else begin
          rdata_d = load_data;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign mem_w_en   = (state_q == ST_WRITE);
  assign rsp_rdata  = rdata_q;
  assign rsp_fault  = fault_q;
  assign mem_addr   = addr_q;
  assign mem_w_data = wword_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: reference model predicts each response and write, monitor compares.
module tb_load_store_unit;

  localparam int MEMSZ = 262144;
  localparam int MASK  = MEMSZ - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic        mem_w_en;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .mem_addr   (mem_addr),
    .mem_w_en   (mem_w_en),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data)
  );

  always #5 clk = ~clk;

  logic [7:0] mem     [0:MEMSZ-1];
  logic [7:0] ref_mem [0:MEMSZ-1];

  wire [17:0] ra = mem_addr[17:0];
  assign mem_r_data = {mem[ra + 18'd3], mem[ra + 18'd2], mem[ra + 18'd1], mem[ra]};

  always @(posedge clk) begin
    if (mem_w_en) begin
      for (int k = 0; k < 4; k++) mem[(int'(ra) + k) & MASK] <= mem_w_data[8*k +: 8];
    end
  end

  typedef struct {
    bit          fault;
    logic [31:0] rdata;
    int          lat;
    int          wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   n_cmp = 0, n_err = 0, n_rsp = 0, wen_total = 0, wr_seen = 0;
  int   cyc = 0, acc_cyc = 0, rdy_mode = 0;
  bit   seen = 0;
  logic [31:0] last_rdata;
  logic        last_fault;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void flag(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event, expected none", name);
  endfunction

  function automatic bit ref_fault(bit w, bit [1:0] sz, logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
           || (a > 32'h0003_FFFB) || (w && a < 32'h0002_0000);
  endfunction

  function automatic logic [31:0] ref_load(bit [1:0] sz, bit sg, logic [31:0] a);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(int'(a) + i) & MASK]) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] a);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < 4; i++) v = v | (32'(ref_mem[(int'(a) + i) & MASK]) << (8 * i));
    return v;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && req_valid && req_ready) acc_cyc <= cyc;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: rsp_ready = 1'b0;
        2: rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops one expectation per response, checks writes and held-response stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_w_en) begin
        wen_total++;
        if (sbq.size() == 0 || sbq[0].wr == 0) flag("unexpected_mem_w_en");
        else begin
          chk("w_addr", mem_addr, sbq[0].waddr);
          chk("w_data", mem_w_data, sbq[0].wdata);
          wr_seen++;
        end
      end
      if (rsp_valid) begin
        if (!seen) begin
          if (sbq.size() == 0) flag("unexpected_rsp_valid");
          else begin
            cur = sbq.pop_front();
            chk("rsp_fault", 32'(rsp_fault), 32'(cur.fault));
            chk("rsp_rdata", rsp_rdata, cur.rdata);
            chk("latency", 32'(cyc - acc_cyc), 32'(cur.lat));
            chk("write_count", 32'(wr_seen), 32'(cur.wr));
            wr_seen = 0;
            last_rdata = rsp_rdata;
            last_fault = rsp_fault;
            n_rsp++;
          end
          seen = 1;
        end else begin
          chk("held_rdata", rsp_rdata, cur.rdata);
          chk("held_fault", 32'(rsp_fault), 32'(cur.fault));
          chk("held_req_ready", 32'(req_ready), 32'd0);
        end
        if (rsp_ready) seen = 0;
      end
    end
  end

  task automatic issue(input bit w, input bit [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.fault = ref_fault(w, sz, a);
    e.rdata = 0;
    e.wr    = 0;
    e.waddr = a;
    e.wdata = 0;
    if (e.fault) e.lat = 1;
    else if (!w) begin
      e.lat   = 2;
      e.rdata = ref_load(sz, sg, a);
    end else begin
      e.lat = 3;
      e.wr  = 1;
      for (int i = 0; i < (1 << sz); i++) ref_mem[(int'(a) + i) & MASK] = wd[8*i +: 8];
      e.wdata = ref_word(a);
    end
    sbq.push_back(e);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    for (int k = 0; k < 200 && !req_ready; k++) @(negedge clk);
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    for (int k = 0; k < 100 && n_rsp < target; k++) @(negedge clk);
    if (n_rsp < target) chk("rsp_timeout", 32'(n_rsp), 32'(target));
  endtask

  task automatic do_op(input bit w, input bit [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd);
    int t;
    t = n_rsp + 1;
    issue(w, sz, sg, a, wd);
    wait_rsp(t);
  endtask

  initial begin
    int w0, ndiff, sel;
    logic [31:0] a;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, ndiff, sel;
    logic [31:0] a;
    for (int i = 0; i < MEMSZ; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    mem['hFA] = 8'hFF; mem['hFB] = 8'hDC; mem['hFC] = 8'hBA; mem['hFD] = 8'h98;
    ref_mem['hFA] = 8'hFF; ref_mem['hFB] = 8'hDC; ref_mem['hFC] = 8'hBA; ref_mem['hFD] = 8'h98;
    mem['h20010] = 8'h44; mem['h20011] = 8'h33; mem['h20012] = 8'h22; mem['h20013] = 8'h11;
    ref_mem['h20010] = 8'h44; ref_mem['h20011] = 8'h33; ref_mem['h20012] = 8'h22; ref_mem['h20013] = 8'h11;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_w_en", 32'(mem_w_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_w_data", mem_w_data, 32'd0);

    do_op(0, 2'd0, 0, 32'h0000_00FA, 0);
    chk("ldbu_FA", last_rdata, 32'h0000_00FF);
    do_op(0, 2'd1, 1, 32'h0000_00FA, 0);
    chk("ldhs_FA", last_rdata, 32'hFFFF_DCFF);
    do_op(0, 2'd0, 1, 32'h0000_00FD, 0);
    chk("ldbs_FD", last_rdata, 32'hFFFF_FF98);

    w0 = wen_total;
    do_op(1, 2'd0, 0, 32'h0002_0010, 32'h0000_0055);
    chk("stb_wen_cycles", 32'(wen_total - w0), 32'd1);
    do_op(0, 2'd2, 0, 32'h0002_0010, 0);
    chk("ldw_after_stb", last_rdata, 32'h1122_3355);

    w0 = wen_total;
    do_op(0, 2'd2, 0, 32'h0002_0002, 0);
    chk("flt_misal_word", 32'(last_fault), 32'd1);
    do_op(1, 2'd1, 0, 32'h0002_0001, 32'h0000_ABCD);
    chk("flt_misal_half_st", 32'(last_fault), 32'd1);
    do_op(1, 2'd2, 0, 32'h0000_0100, 32'hCAFE_F00D);
    chk("flt_rom_store", 32'(last_fault), 32'd1);
    do_op(0, 2'd3, 0, 32'h0002_0010, 0);
    chk("flt_size3", 32'(last_fault), 32'd1);
    chk("flt_no_wen", 32'(wen_total - w0), 32'd0);
    chk("flt_mem_intact", {mem['h20013], mem['h20012], mem['h20011], mem['h20010]}, 32'h1122_3355);

    // Response held by the consumer for five cycles, then released.
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    issue(0, 2'd0, 0, 32'h0000_00FA, 0);
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, 32'h0000_00FF);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("release_req_ready", 32'(req_ready), 32'd1);
    chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
    rdy_mode = 0;

    // Reset lands while a store is in ACCESS: nothing may be written or answered.
    req_write = 1; req_size = 2'd2; req_signed = 0; req_addr = 32'h0002_0020; req_wdata = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("access_mem_addr", mem_addr, 32'h0002_0020);
    rst = 1'b1;
    w0 = wen_total;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_req_ready", 32'(req_ready), 32'd1);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_mem_w_en", 32'(mem_w_en), 32'd0);
    chk("rstmid_mem_addr", mem_addr, 32'd0);
    repeat (4) @(negedge clk);
    chk("rstmid_no_wen", 32'(wen_total - w0), 32'd0);
    chk("rstmid_word", {mem['h20023], mem['h20022], mem['h20021], mem['h20020]}, ref_word(32'h0002_0020));

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: a = 32'h0001_FFF0 + $urandom_range(0, 47);
        1: a = 32'h0003_FFF0 + $urandom_range(0, 15);
        2: a = 32'h0000_00F0 + $urandom_range(0, 31);
        3: a = 32'h0002_0040 + $urandom_range(0, 63);
        default: a = $urandom;
      endcase
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end
    wait_rsp(n_rsp + sbq.size());

    ndiff = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) ndiff++;
    chk("mem_diff_bytes", 32'(ndiff), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
